// File: rtl/instruction_prefetch_unit.sv
// instruction_prefetch_unit: pipelined-bus prefetcher feeding decode from a DEPTH-entry FIFO; define IFU_ABORT_TAG_EN to tag aborted fetches and halt fetching until flush
module instruction_prefetch_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic clk,
  input  logic n_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0] mem_trans,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic mem_ready,
  input  logic mem_abort,
  input  logic flush_i,
  input  logic [ADDR_W-1:0] flush_addr_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic instr_abort_o,
  output logic instr_valid_o,
  input  logic instr_ready_i,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DEPTH-1:0] abort_mem;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [1:0] trans_q;
  logic pend_q, stop_q, stop_nxt, accept, complete, wr_en, rd_en, tag, credit;
  logic [DATA_W-1:0] last_instr;
  logic [ADDR_W-1:0] last_pc;
  logic last_abort;
  assign accept = mem_ready & (|trans_q);
  assign complete = mem_ready & pend_q;
  assign wr_en = complete & ~flush_i;
  assign rd_en = instr_valid_o & instr_ready_i;
  assign count_nxt = count + CW'(wr_en) - CW'(rd_en);
`ifdef IFU_ABORT_TAG_EN
  assign tag = mem_abort;
`else
  logic unused_abort;
  assign unused_abort = mem_abort;
  assign tag = 1'b0;
`endif
  assign stop_nxt = stop_q | (complete & tag);
  // a slot is reserved for the fetch about to be accepted as well as for the buffered words
  assign credit = ((count_nxt + CW'(accept)) < CW'(DEPTH)) && !stop_nxt;
  // the first fetch is presented as soon as reset releases; only the reset itself forces idle
  assign mem_trans = n_reset ? trans_q : 2'b00;
  assign instr_valid_o = |count;
  assign count_o = count;
  assign instr_o = instr_valid_o ? data_mem[rd_ptr] : last_instr;
  assign instr_pc_o = instr_valid_o ? pc_mem[rd_ptr] : last_pc;
  assign instr_abort_o = instr_valid_o ? abort_mem[rd_ptr] : last_abort;
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr] <= mem_addr - ADDR_W'(1);
      abort_mem[wr_ptr] <= tag;
    end
  end
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      trans_q <= 2'b10;
      mem_addr <= RESET_PC;
      pend_q <= 1'b0;
      stop_q <= 1'b0;
      last_instr <= '0;
      last_pc <= '0;
      last_abort <= 1'b0;
    end else begin
      if (instr_valid_o && (rd_en || flush_i)) begin
        last_instr <= instr_o;
        last_pc <= instr_pc_o;
        last_abort <= instr_abort_o;
      end
      if (flush_i) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        pend_q <= 1'b0;
        stop_q <= 1'b0;
        trans_q <= 2'b10;
        mem_addr <= flush_addr_i;
      end else begin
        rd_ptr <= rd_ptr + PW'(rd_en);
        wr_ptr <= wr_ptr + PW'(wr_en);
        count <= count_nxt;
        if (mem_ready) begin
          pend_q <= accept;
          stop_q <= stop_nxt;
          mem_addr <= mem_addr + ADDR_W'(accept);
          trans_q <= credit ? (accept ? 2'b11 : 2'b10) : 2'b00;
        end
      end
    end
  end
endmodule
